// File: rtl/cond_pkg.sv
// Shared types and flag/write-enable bit positions for the conditional-execution unit.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: (Cond, Flags) -> CondEx.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b1;
    case (cond_t'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      // AL and the reserved 1111 code both execute unconditionally
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional unit: flag register, write-enable gating, and
// optional fire statistics enabled by defining COND_STATS_EN.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags
`ifdef COND_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_exec,
  output logic [CNT_W-1:0] cnt_squash
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       fire;
  logic       gate;

  assign fire  = valid & en;
  assign Flags = flags_q;

  // Condition sees only the committed flags, never this instruction's ALU result
  cond_check u_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  // Reset level forces the write strobes low even before any clock edge
  assign gate     = fire & CondEx & reset_n;
  assign PCSrc    = gate & PCS;
  assign RegWrite = gate & RegW & ~NoWrite;
  assign MemWrite = gate & MemW;

  always_comb begin
    flags_d = flags_q;
    if (fire && CondEx) begin
      if (FlagW[FLAGW_NZ]) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[FLAGW_CV]) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= 4'b0000;
    else          flags_q <= flags_d;
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] squash_q, squash_d;

  assign cnt_exec   = exec_q;
  assign cnt_squash = squash_q;

  // Clear wins over increment; both counters stick at all-ones
  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    if (stats_clr) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (fire) begin
      if (CondEx) begin
        if (exec_q != {CNT_W{1'b1}}) exec_d = exec_q + 1'b1;
      end else begin
        if (squash_q != {CNT_W{1'b1}}) squash_d = squash_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes expectations, a negedge monitor checks them.
module tb_cond_unit;

`ifdef COND_STATS_EN
  localparam int TB_CNT_W = 3;
`else
  localparam int TB_CNT_W = 32;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic                en, valid;
  logic [3:0]          Cond, ALUFlags;
  logic [1:0]          FlagW;
  logic                PCS, RegW, MemW, NoWrite;
  logic                PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]          Flags;
  logic                stats_clr;
  logic [TB_CNT_W-1:0] cnt_exec, cnt_squash;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .valid    (valid),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
`ifdef COND_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .cnt_exec   (cnt_exec),
    .cnt_squash (cnt_squash)
`endif
  );

`ifndef COND_STATS_EN
  assign cnt_exec   = '0;
  assign cnt_squash = '0;
`endif

  typedef struct {
    string               name;
    logic                pc, rw, mw, cx;
    logic [3:0]          fl;
    logic [TB_CNT_W-1:0] ex, sq;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [TB_CNT_W-1:0] exp_exec = '0;
  logic [TB_CNT_W-1:0] exp_squash = '0;
  logic                sc_next = 1'b0;

  task automatic chk(input string nm, input string sig, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s.%s: got %0h expected %0h", nm, sig, act, req);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.name, "PCSrc",    32'(PCSrc),    32'(x.pc));
      chk(x.name, "RegWrite", 32'(RegWrite), 32'(x.rw));
      chk(x.name, "MemWrite", 32'(MemWrite), 32'(x.mw));
      chk(x.name, "CondEx",   32'(CondEx),   32'(x.cx));
      chk(x.name, "Flags",    32'(Flags),    32'(x.fl));
`ifdef COND_STATS_EN
      chk(x.name, "cnt_exec",   32'(cnt_exec),   32'(x.ex));
      chk(x.name, "cnt_squash", 32'(cnt_squash), 32'(x.sq));
`endif
    end
  end

  task automatic push(input string nm, input logic epc, erw, emw, ecx, input logic [3:0] efl);
    exp_t e;
    e.name = nm; e.pc = epc; e.rw = erw; e.mw = emw; e.cx = ecx; e.fl = efl;
    e.ex = exp_exec; e.sq = exp_squash;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic rn, input logic [3:0] c, alu, input logic [1:0] fw,
                      input logic p, r, m, nw, v, e,
                      input logic epc, erw, emw, ecx, input logic [3:0] efl);
    @(posedge clk);
    #1;
    reset_n = rn; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw; valid = v; en = e;
    stats_clr = sc_next;
    push(nm, epc, erw, emw, ecx, efl);
    // counter state expected after the coming edge
    if (!rn || sc_next) begin
      exp_exec = '0; exp_squash = '0;
    end else if (v && e) begin
      if (ecx) begin
        if (exp_exec != {TB_CNT_W{1'b1}}) exp_exec = exp_exec + 1'b1;
      end else begin
        if (exp_squash != {TB_CNT_W{1'b1}}) exp_squash = exp_squash + 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0; valid = 1'b1; en = 1'b1;
    stats_clr = 1'b0;
    #1;
    push("rst_hold", 0, 0, 0, 1, 4'b0000);
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    //    name            rn cond     alu      fw     P  R  M  NW V  E   pc rw mw cx flags
    step("eq_rst",        1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 4'b0000);
    step("ne_rst",        1, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b0000);
    step("cmp55",         1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1, 1, 1,  0, 0, 0, 1, 4'b0000);
    step("eq_after_cmp",  1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 1,  0, 1, 0, 1, 4'b0110);
    step("cs_after_cmp",  1, 4'b0010, 4'b0000, 2'b00, 0, 0, 1, 0, 1, 1,  0, 0, 1, 1, 4'b0110);
    step("ls_after_cmp",  1, 4'b1001, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b0110);
    step("subs35",        1, 4'b1110, 4'b1000, 2'b11, 0, 1, 0, 0, 1, 1,  0, 1, 0, 1, 4'b0110);
    step("lt_pass",       1, 4'b1011, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b1000);
    step("mi_pass",       1, 4'b0100, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b1000);
    step("cc_pass",       1, 4'b0011, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b1000);
    step("ge_fail",       1, 4'b1010, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 4'b1000);
    step("cs_fail",       1, 4'b0010, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 4'b1000);
    step("hi_fail",       1, 4'b1000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 4'b1000);
    step("set0011",       1, 4'b1110, 4'b0011, 2'b11, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 4'b1000);
    step("fw_nz_only",    1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 4'b0011);
    step("fw_cv_only",    1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 4'b1111);
    step("gt_fail_setter",1, 4'b1100, 4'b0000, 2'b11, 1, 1, 1, 0, 1, 1,  0, 0, 0, 0, 4'b1100);
    step("stall",         1, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 1, 0,  0, 0, 0, 1, 4'b1100);
    step("bubble",        1, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 0, 1,  0, 0, 0, 1, 4'b1100);
    step("flags_held",    1, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 1, 1,  1, 1, 1, 1, 4'b1100);
    step("le_pass",       1, 4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b1100);
    step("async_rst",     0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1,  0, 0, 0, 1, 4'b0000);
    step("ne_post_rst",   1, 4'b0001, 4'b0000, 2'b00, 1, 1, 1, 0, 1, 1,  1, 1, 1, 1, 4'b0000);
    step("eq_fail_cnt",   1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 4'b0000);
    sc_next = 1'b1;
    step("clr_with_fire", 1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 4'b0000);
    sc_next = 1'b0;
    step("after_clr",     1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 4'b0000);

    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (q.size() != 0) $display("FAIL drain: %0d expectations left, required 0", q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit that consumes the 4-bit `{N,Z,C,V}` flag vector produced by the ALU. It holds the architectural flag register, evaluates the instruction's 4-bit condition field against the stored flags, and gates PC, register-file and memory write enables. It sits in the execute stage of the single-cycle, multicycle and pipelined cores, directly downstream of the ALU.

## Interface
Parameters:
- `CNT_W`, default 32: width of the statistics counters (used only with `COND_STATS_EN`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  stage advance; 0 = stall.
- `valid`  in  1  execute-stage slot holds a real instruction; 0 = bubble or flush.
- `Cond`  in  4  instruction condition field `[31:28]`.
- `ALUFlags`  in  4  ALU flags `{N,Z,C,V}` of the current instruction.
- `FlagW`  in  2  bit 1 writes N,Z; bit 0 writes C,V.
- `PCS`  in  1  instruction writes the PC.
- `RegW`  in  1  instruction writes the register file.
- `MemW`  in  1  instruction writes memory.
- `NoWrite`  in  1  CMP/TST-class instruction; suppresses the register write.
- `PCSrc`  out  1  gated PC write.
- `RegWrite`  out  1  gated register write.
- `MemWrite`  out  1  gated memory write.
- `CondEx`  out  1  condition passed (ungated by `valid`/`en`).
- `Flags`  out  4  current flag register `{N,Z,C,V}`.
- `stats_clr`  in  1  synchronous counter clear (only with `COND_STATS_EN`).
- `cnt_exec`  out  `CNT_W`  count of fired instructions whose condition passed (only with `COND_STATS_EN`).
- `cnt_squash`  out  `CNT_W`  count of fired instructions whose condition failed (only with `COND_STATS_EN`).

## Operation
- `fire = valid & en`.
- `CondEx` is evaluated from the registered `Flags`, never from `ALUFlags`. An instruction's own flags do not affect its own condition.
- Condition table:
  - EQ 0000: Z
  - NE 0001: ~Z
  - CS 0010: C
  - CC 0011: ~C
  - MI 0100: N
  - PL 0101: ~N
  - VS 0110: V
  - VC 0111: ~V
  - HI 1000: C&~Z
  - LS 1001: ~C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: ~Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - 1111: 1 (treated as unconditional)
- Output gating:
  - `PCSrc = fire & PCS & CondEx`
  - `RegWrite = fire & RegW & CondEx & ~NoWrite`
  - `MemWrite = fire & MemW & CondEx`
- Flag update on the clock edge, when `fire & CondEx`:
  - `FlagW[1]` loads `Flags[3:2] <= ALUFlags[3:2]`.
  - `FlagW[0]` loads `Flags[1:0] <= ALUFlags[1:0]`.
  - The two halves are independent.
- A failed condition, a bubble, or a stall leaves `Flags` unchanged.
- C follows the ALU convention: after a subtract, C = NOT borrow, so CS means unsigned A >= B.

## Timing
- Gating outputs are combinational from the inputs and `Flags`, with zero latency.
- `Flags` reflects a write one cycle after the firing edge. The next instruction sees the new flags with no forwarding needed.
- `en=0`: all gated outputs are 0, and `Flags` and the counters hold.
- `valid=0` with `en=1`: same as a stall; outputs 0, no state change.
- Reset values: `Flags=4'b0000`, counters 0.
- While `reset_n=0`, `PCSrc`, `RegWrite` and `MemWrite` are forced to 0, regardless of `valid`/`en`.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Post-reset flags are all zero, so NE, CC, PL and VC pass and EQ fails.

## Configuration
- `COND_STATS_EN` defined:
  - Adds `stats_clr`, `cnt_exec` and `cnt_squash`.
  - On a firing edge, `cnt_exec` increments if `CondEx`, otherwise `cnt_squash` increments.
  - Both counters saturate at all-ones.
  - `stats_clr` takes priority over increment.
- `COND_STATS_EN` undefined: those ports and registers do not exist. Behaviour is otherwise identical.

## Structure
- Package `cond_pkg`:
  - `cond_t` enum for the 16 codes.
  - Flag index localparams `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `FLAGW_NZ=1`, `FLAGW_CV=0`.
- Sub-module `cond_check`: purely combinational, (`Cond`, `Flags`) → `CondEx`. Reused by the pipelined core's branch predictor check.
- Top level holds the flag register, output gating and optional counters.

## Test plan
- Reset, then `Cond=0000` with `PCS=1`, `valid=en=1` → `Flags=0000`, `CondEx=0`, `PCSrc=0`. `Cond=0001` → `PCSrc=1`.
- CMP 5,5: `ALUFlags=0110`, `FlagW=11`, `NoWrite=1`, `RegW=1` → `RegWrite=0`. Next cycle `Flags=0110`, and EQ, CS and LS pass.
- SUBS 3−5: `ALUFlags=1000`, `FlagW=11` → next cycle `Flags=1000`. LT, MI and CC pass; GE, CS and HI fail.
- `FlagW=10` with `ALUFlags=1111` over `Flags=0011` → `Flags=1111`. Then `FlagW=01` with `ALUFlags=0000` → `Flags=1100`.
- Conditional flag-setter with a failing `Cond`, or `en=0`, or `valid=0` → `Flags` unchanged and all gated outputs 0. Assert `reset_n` low mid-cycle → `Flags=0000` immediately.
- With `COND_STATS_EN`: 3 passing and 2 failing fires, plus 1 stall → `cnt_exec=3`, `cnt_squash=2`. Preload `cnt_exec` to all-ones and fire → stays all-ones. Assert `stats_clr` together with a fire → 0.
